// File: rtl/counter_share_arbiter.sv
// counter_share_arbiter: one WIDTH-bit up/down counter shared by NREQ requesters.
// A round-robin arbiter grants one single-step request at a time, so at most one
// step is applied every two cycles.
// Build option: define COUNTER_SAT_EN for a saturating counter (default wraps).
module counter_share_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clr,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  dir,
    output logic [NREQ-1:0]  gnt,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             ovf
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = PW + 1;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StGrant = 1'b1;

    localparam logic [WIDTH-1:0] CntMax  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CntZero = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CntOne  = WIDTH'(1);
    localparam logic [NREQ-1:0]  GntOne  = NREQ'(1);
    localparam logic [PW-1:0]    LastIdx = PW'(NREQ - 1);
    localparam logic [PW-1:0]    IdxOne  = PW'(1);
    localparam logic [CW-1:0]    NreqCw  = CW'(NREQ);

    logic [0:0]       state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             dir_q, dir_d;
    logic [PW-1:0]    win_q, win_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;

    logic             win_found;
    logic [PW-1:0]    win_idx;
    logic [CW-1:0]    cand;
    logic [PW-1:0]    cand_idx;

    // Round-robin search: first set req bit at or after rr_ptr, wrapping at NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        cand_idx  = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = {1'b0, rr_ptr_q} + CW'(off);
            if (cand >= NreqCw) begin
                cand = cand - NreqCw;
            end
            cand_idx = cand[PW-1:0];
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Next-state logic for the two-state grant FSM and the shared counter.
    always_comb begin
        state_d  = state_q;
        gnt_d    = '0;
        count_d  = count_q;
        ovf_d    = 1'b0;
        dir_d    = dir_q;
        win_d    = win_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            StIdle: begin
                if (clr) begin
                    count_d = CntZero;
                end else if (enable && win_found) begin
                    win_d   = win_idx;
                    dir_d   = dir[win_idx];
                    gnt_d   = GntOne << win_idx;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                state_d = StIdle;
                // A clear aborts the step and leaves the round-robin pointer alone.
                if (clr) begin
                    count_d = CntZero;
                end else begin
                    rr_ptr_d = (win_q == LastIdx) ? '0 : win_q + IdxOne;
                    if (dir_q) begin
                        if (count_q == CntMax) begin
                            ovf_d = 1'b1;
`ifdef COUNTER_SAT_EN
                            count_d = CntMax;
`else
                            count_d = CntZero;
`endif
                        end else begin
                            count_d = count_q + CntOne;
                        end
                    end else begin
                        if (count_q == CntZero) begin
                            ovf_d = 1'b1;
`ifdef COUNTER_SAT_EN
                            count_d = CntZero;
`else
                            count_d = CntMax;
`endif
                        end else begin
                            count_d = count_q - CntOne;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset discards any in-flight step immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            gnt_q    <= '0;
            count_q  <= CntZero;
            ovf_q    <= 1'b0;
            dir_q    <= 1'b0;
            win_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            dir_q    <= dir_d;
            win_q    <= win_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign gnt   = gnt_q;
    assign count = count_q;
    assign busy  = (state_q == StGrant);
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Testbench for counter_share_arbiter: directed scenarios plus random traffic,
// checked cycle by cycle against a transaction-level reference model through a queue.
module tb_counter_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;
`ifdef COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b1;
    logic             clr = 1'b0;
    logic [NREQ-1:0]  req = '0;
    logic [NREQ-1:0]  dir = '0;
    logic [NREQ-1:0]  gnt;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             ovf;

    counter_share_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk    (clk),
        .reset  (rst_n),
        .enable (enable),
        .clr    (clr),
        .req    (req),
        .dir    (dir),
        .gnt    (gnt),
        .count  (count),
        .busy   (busy),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NREQ-1:0]  gnt;
        logic [WIDTH-1:0] count;
        logic             busy;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    int   glog[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: the counter value, the pending step (if any), rr pointer.
    int m_count;
    bit m_pending;
    int m_w;
    bit m_up;
    int m_ptr;
    bit m_ovf;

    function automatic int pick(logic [NREQ-1:0] r, int ptr);
        for (int o = 0; o < NREQ; o++) begin
            if (r[(ptr + o) % NREQ]) return (ptr + o) % NREQ;
        end
        return -1;
    endfunction

    always @(negedge rst_n) begin
        m_count   = 0;
        m_pending = 1'b0;
        m_w       = 0;
        m_up      = 1'b0;
        m_ptr     = 0;
        m_ovf     = 1'b0;
        exp_q.delete();
    end

    // Model: decide what each clock edge does, push the expected visible outputs.
    always @(posedge clk) begin
        exp_t e;
        int   nxt;
        int   w;
        if (!rst_n) begin
            e = '0;
        end else begin
            m_ovf = 1'b0;
            if (m_pending) begin
                m_pending = 1'b0;
                if (clr) begin
                    m_count = 0;
                end else begin
                    nxt = m_count + (m_up ? 1 : -1);
                    if (nxt > MAXV || nxt < 0) begin
                        m_ovf = 1'b1;
                        nxt   = SAT ? m_count : (nxt & MAXV);
                    end
                    m_count = nxt;
                    m_ptr   = (m_w + 1) % NREQ;
                end
            end else if (clr) begin
                m_count = 0;
            end else if (enable) begin
                w = pick(req, m_ptr);
                if (w >= 0) begin
                    m_pending = 1'b1;
                    m_w       = w;
                    m_up      = dir[w];
                end
            end
            e.gnt   = m_pending ? NREQ'(1 << m_w) : '0;
            e.count = m_count[WIDTH-1:0];
            e.busy  = m_pending;
            e.ovf   = m_ovf;
        end
        exp_q.push_back(e);
    end

    // Monitor: compare DUT outputs against the oldest expectation away from the edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (gnt !== e.gnt || count !== e.count || busy !== e.busy || ovf !== e.ovf) begin
                errors++;
                $display("FAIL outputs t=%0t actual gnt=%b count=%0d busy=%b ovf=%b required gnt=%b count=%0d busy=%b ovf=%b",
                         $time, gnt, count, busy, ovf, e.gnt, e.count, e.busy, e.ovf);
            end
            checks++;
            if ($countones(gnt) > 1 || busy !== (gnt != '0)) begin
                errors++;
                $display("FAIL onehot_busy t=%0t actual gnt=%b busy=%b required onehot gnt matching busy",
                         $time, gnt, busy);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) glog.push_back(i);
            end
        end
    end

    // Asynchronous reset placed between edges; outputs must clear at once.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== '0 || count !== '0 || busy !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL async_reset actual gnt=%b count=%0d busy=%b ovf=%b required all zero",
                     gnt, count, busy, ovf);
        end
        req = '0;
        clr = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // One single-cycle request from requester i, then idle through the exit edge.
    task automatic step(int i, bit up);
        @(negedge clk);
        req    = '0;
        req[i] = 1'b1;
        dir[i] = up;
        @(negedge clk);
        req = '0;
    endtask

    initial begin
        // Test 1: power-on reset, one step, then reset while a step is in flight.
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        step(0, 1'b1);
        @(negedge clk);
        req = 4'b0001;
        dir = 4'b0001;
        @(negedge clk);
        req = '0;
        do_reset();
        step(0, 1'b1);

        // Test 2: all four requesting up; strict rotation from requester 0.
        @(negedge clk);
        do_reset();
        @(negedge clk);
        glog.delete();
        enable = 1'b1;
        req    = 4'b1111;
        dir    = 4'b1111;
        repeat (16) @(negedge clk);
        req = '0;
        checks++;
        if (glog.size() != 8) begin
            errors++;
            $display("FAIL grant_count actual %0d required 8", glog.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (glog[i] != i % NREQ) begin
                    errors++;
                    $display("FAIL grant_order slot %0d actual %0d required %0d", i, glog[i], i % NREQ);
                end
            end
        end
        checks++;
        if (count !== 4'd8) begin
            errors++;
            $display("FAIL count_after_rotation actual %0d required 8", count);
        end

        // Test 3: up across max, then down across zero.
        repeat (7) step(2, 1'b1);
        step(2, 1'b1);
        step(1, 1'b0);
        repeat (2) @(negedge clk);

        // Test 4: clear during a grant from count 5; pointer must not advance.
        @(negedge clk);
        do_reset();
        repeat (5) step(0, 1'b1);
        @(negedge clk);
        req = 4'b0110;
        dir = 4'b0110;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);

        // Test 5: enable low holds off grants; first grant after enable goes to 1.
        do_reset();
        @(negedge clk);
        enable = 1'b0;
        req    = 4'b0110;
        repeat (10) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        req = '0;
        repeat (2) @(negedge clk);

        // Test 6: requesters 0 (up) and 3 (down) contend from count 7.
        do_reset();
        repeat (7) step(3, 1'b1);
        @(negedge clk);
        req = 4'b1001;
        dir = 4'b0001;
        repeat (8) @(negedge clk);
        req = '0;
        repeat (2) @(negedge clk);

        // Random traffic with occasional clears, enable drops and resets.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            req    = NREQ'($urandom);
            dir    = NREQ'($urandom);
            enable = ($urandom_range(0, 9) != 0);
            clr    = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 149) == 0) do_reset();
        end
        @(negedge clk);
        req    = '0;
        clr    = 1'b0;
        enable = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual %0d entries required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
